reg_wb: RTL
===========

REG_WB -- requirements
Module: reg_wb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning register data width.
REQ-002 SHALL have parameter NR_REGS, default 32, meaning architectural register count (index width 5).
REQ-003 SHALL have clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have in_valid/in_ready  input/output  1/1  the upstream result handshake; transfer occurs when both are high on a clk edge.
REQ-006 SHALL have in_rd  input  5  the destination register index.
REQ-007 SHALL have in_sel  input  2  the result source: 00 ALU, 01 LOAD, 10 PC+4, 11 no-write.
REQ-008 SHALL have in_alu, in_pc  input  DATA_WIDTH each  the ALU result and the instruction PC.
REQ-009 SHALL have in_funct3, in_addr_lo  input  3/3  the load size/sign and the byte offset.
REQ-010 SHALL have mem_rvalid, mem_rdata  input  1/DATA_WIDTH  the load data return, one-cycle pulse.
REQ-011 SHALL have wen, waddr, wdata  output  1/5/DATA_WIDTH  the register-file write port.
REQ-012 SHALL have iss_valid, iss_rd  input  1/5  the issue-side scoreboard set request.
REQ-013 SHALL have busy  output  NR_REGS  the pending-write bitmap used by decode for hazard stall.

Function
REQ-014 SHALL implement FSM states IDLE and WAIT_MEM; in_ready = (state==IDLE) and not rst.
REQ-015 SHALL in IDLE, on transfer with in_sel 00/10, register wen=1 for exactly one cycle, the cycle after the transfer (latency 1), with wdata = in_alu or in_pc+4 (mod 2^DATA_WIDTH).
REQ-016 SHALL in IDLE, on transfer with in_sel 01, latch in_rd/in_funct3/in_addr_lo and go to WAIT_MEM with wen=0.
REQ-017 SHALL in WAIT_MEM, on mem_rvalid, drive wen=1 the next cycle with wdata = extended load data, then return to IDLE in that same cycle.
REQ-018 SHALL extend loads by shifting mem_rdata right 8*in_addr_lo bits, then LB 000/LH 001/LW 010 sign-extend, LD 011 pass through, LBU 100/LHU 101/LWU 110 zero-extend; funct3 111 gives zero.
REQ-019 SHALL suppress the write (wen=0) when rd==0 or in_sel==11, while still completing the handshake and FSM path.
REQ-020 SHALL allow back-to-back non-load transfers, one per cycle, with wen held high for consecutive cycles.
REQ-021 SHALL ignore mem_rvalid in IDLE.
REQ-022 SHALL set busy[iss_rd] on iss_valid when iss_rd!=0, and clear busy[waddr] on the cycle wen=1.
REQ-023 SHALL give set priority when set and clear address the same register in the same cycle; busy[0] is constantly 0.

Reset
REQ-024 SHALL, while rst is high, force state=IDLE, wen=0, waddr=0, wdata=0, busy=0, in_ready=0.
REQ-025 SHALL, on rst during WAIT_MEM, abandon the pending load; a later mem_rvalid causes no write.

Configuration
REQ-026 SHALL, with WB_FORWARD_EN defined, add outputs fwd_valid (=wen), fwd_rd (=waddr) and fwd_data (=wdata) so decode can bypass a same-cycle register-file read; busy is cleared one cycle earlier, in the cycle the wen register is loaded.
REQ-027 SHALL, without WB_FORWARD_EN, omit the fwd_* ports and clear busy as in REQ-022.

Structure
REQ-028 SHALL place the in_sel encodings, load funct3 codes and the DATA_WIDTH default in shared package rv_pkg.
REQ-029 SHALL implement the load extension as combinational sub-module load_ext.

Verification
REQ-030 ALU: in_sel=00, rd=5, in_alu=0x1234 -> next cycle wen=1, waddr=5, wdata=0x1234; busy[5] cleared.
REQ-031 LB: funct3=000, addr_lo=3, mem_rdata=0x0000_0000_8000_0000, rvalid 4 cycles later -> in_ready=0 for 4 cycles, then wdata=0xFFFF_FFFF_FFFF_FF80.
REQ-032 x0: rd=0, in_sel=10, pc=0x8000_0000 -> wen stays 0; busy[0] stays 0; in_ready high next cycle.
REQ-033 Collision: iss_rd=7 in the same cycle as the write to rd 7 -> busy[7]=1 afterwards.
REQ-034 Reset: rst asserted in WAIT_MEM, mem_rvalid 2 cycles after release -> no wen, state IDLE.
REQ-035 Throughput: 3 back-to-back ALU ops to rd 1/2/3 -> wen high 3 consecutive cycles, with waddr 1, 2, 3 in order.

Source files
------------

// File: rtl/rv_pkg.sv
// rv_pkg: shared writeback encodings (result select, load funct3) and default data width
package rv_pkg;
  localparam int DATA_WIDTH_DEF = 64;
  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
endpackage

// File: rtl/load_ext.sv
// load_ext: aligns returned load data by byte offset and sign/zero-extends it by funct3
module load_ext import rv_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [2:0]            funct3_i,
  input  logic [2:0]            addr_lo_i,
  output logic [DATA_WIDTH-1:0] data_o
);
  logic [DATA_WIDTH-1:0] s;
  assign s = rdata_i >> {addr_lo_i, 3'b000};
  // pick the extension for the access size; unused funct3 yields zero
  always_comb begin
    case (funct3_i)
      F3_LB:   data_o = {{(DATA_WIDTH-8){s[7]}}, s[7:0]};
      F3_LH:   data_o = {{(DATA_WIDTH-16){s[15]}}, s[15:0]};
      F3_LW:   data_o = {{(DATA_WIDTH-32){s[31]}}, s[31:0]};
      F3_LD:   data_o = s;
      F3_LBU:  data_o = {{(DATA_WIDTH-8){1'b0}}, s[7:0]};
      F3_LHU:  data_o = {{(DATA_WIDTH-16){1'b0}}, s[15:0]};
      F3_LWU:  data_o = {{(DATA_WIDTH-32){1'b0}}, s[31:0]};
      default: data_o = '0;
    endcase
  end
endmodule

// File: rtl/reg_wb.sv
// reg_wb: writeback stage with load wait FSM and busy scoreboard; WB_FORWARD_EN adds fwd_* bypass ports
module reg_wb import rv_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NR_REGS    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            in_rd,
  input  logic [1:0]            in_sel,
  input  logic [DATA_WIDTH-1:0] in_alu,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [2:0]            in_funct3,
  input  logic [2:0]            in_addr_lo,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  wen,
  output logic [4:0]            waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic                  iss_valid,
  input  logic [4:0]            iss_rd,
  output logic [NR_REGS-1:0]    busy
`ifdef WB_FORWARD_EN
  ,
  output logic                  fwd_valid,
  output logic [4:0]            fwd_rd,
  output logic [DATA_WIDTH-1:0] fwd_data
`endif
);
  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_MEM = 1'b1;
  logic [0:0]            state_q, state_d;
  logic [4:0]            rd_q, rd_d, waddr_q, waddr_d, clr_addr;
  logic [2:0]            f3_q, f3_d, lo_q, lo_d;
  logic                  wen_q, wen_d, xfer, clr_en;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, ld_data;
  logic [NR_REGS-1:0]    busy_q, busy_d;
  assign in_ready = state_q == IDLE && !rst;
  assign xfer     = in_valid && in_ready;
  assign wen      = wen_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign busy     = busy_q;
`ifdef WB_FORWARD_EN
  assign fwd_valid = wen_q;
  assign fwd_rd    = waddr_q;
  assign fwd_data  = wdata_q;
  assign clr_en    = wen_d;
  assign clr_addr  = waddr_d;
`else
  assign clr_en    = wen_q;
  assign clr_addr  = waddr_q;
`endif
  load_ext #(.DATA_WIDTH(DATA_WIDTH)) u_load_ext (
    .rdata_i  (mem_rdata),
    .funct3_i (f3_q),
    .addr_lo_i(lo_q),
    .data_o   (ld_data)
  );
  // accept results, park loads until data returns, and stage one write per cycle
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    f3_d    = f3_q;
    lo_d    = lo_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (state_q == IDLE) begin
      if (xfer && in_sel == SEL_LOAD) begin
        state_d = WAIT_MEM;
        rd_d    = in_rd;
        f3_d    = in_funct3;
        lo_d    = in_addr_lo;
      end else if (xfer && in_sel != SEL_NONE) begin
        wen_d   = in_rd != 5'd0;
        waddr_d = in_rd;
        wdata_d = in_sel == SEL_PC4 ? in_pc + DATA_WIDTH'(4) : in_alu;
      end
    end else if (mem_rvalid) begin
      state_d = IDLE;
      wen_d   = rd_q != 5'd0;
      waddr_d = rd_q;
      wdata_d = ld_data;
    end
  end
  // issue sets win over writeback clears; x0 never pending
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (iss_valid) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q    <= '0;
      f3_q    <= '0;
      lo_q    <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      f3_q    <= f3_d;
      lo_q    <= lo_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end
endmodule
